// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared opcodes, FSM states and access decode for mem_ctrl
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    // Trap type raised by the core when MAE is seen
    localparam logic [7:0] TT_MEM_ADDRESS_NOT_ALIGNED = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef struct packed {
        logic  is_store;
        logic  is_signed;
        size_e size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info.is_store  = 1'b0;
        info.is_signed = 1'b0;
        info.size      = SZ_NONE;
        case (op)
            OP_LD:   info.size = SZ_WORD;
            OP_LDUB: info.size = SZ_BYTE;
            OP_LDUH: info.size = SZ_HALF;
            OP_LDSB: begin info.size = SZ_BYTE; info.is_signed = 1'b1; end
            OP_LDSH: begin info.size = SZ_HALF; info.is_signed = 1'b1; end
            OP_ST:   begin info.size = SZ_WORD; info.is_store = 1'b1; end
            OP_STB:  begin info.size = SZ_BYTE; info.is_store = 1'b1; end
            OP_STH:  begin info.size = SZ_HALF; info.is_store = 1'b1; end
            default: info.size = SZ_NONE;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mem_align_ext.sv
// rtl/mem_align_ext.sv - load byte-lane selection and sign/zero extension
module mem_align_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Big-endian lanes: offset 0 is the most significant byte of the word
    always_comb begin
        byte_sel = 8'h00;
        case (byte_off_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = byte_off_i[1] ? word_i[15:0] : word_i[31:16];

        data_o = 32'h0;
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            SZ_WORD: data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-addressed RAM controller with fixed latency; MEM_ALIGN_TRAP_EN enables misalignment traps
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MAE,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0] Mem [0:DEPTH-1];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] dout_q, dout_d;
    logic        mae_q, mae_d;

    op_info_t      info;
    logic [AW-1:0] eff_addr;
    logic [AW-1:0] word_addr;
    logic          trap;
    logic          access;
    logic          do_write;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;

    logic unused_addr;
    assign unused_addr = ^Address[31:AW];

    assign info   = decode_op(op_q);
    assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        eff_addr = addr_q;
        trap     = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
        if (info.size == SZ_WORD) begin
            trap = (addr_q[1:0] != 2'b00);
        end else if (info.size == SZ_HALF) begin
            trap = addr_q[0];
        end
`else
        if (info.size == SZ_WORD) begin
            eff_addr[1:0] = 2'b00;
        end else if (info.size == SZ_HALF) begin
            eff_addr[0] = 1'b0;
        end
`endif
    end

    assign word_addr = {eff_addr[AW-1:2], 2'b00};
    assign rd_word   = {Mem[word_addr], Mem[word_addr + AW'(1)],
                        Mem[word_addr + AW'(2)], Mem[word_addr + AW'(3)]};

    mem_align_ext u_align_ext (
        .word_i     (rd_word),
        .byte_off_i (eff_addr[1:0]),
        .size_i     (info.size),
        .signed_i   (info.is_signed),
        .data_o     (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        mae_d   = mae_q;
        case (state_q)
            ST_IDLE: begin
                if (RAM_enable) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    op_d    = RAM_OpCode;
                    addr_d  = Address[AW-1:0];
                    din_d   = DataIn;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    mae_d   = trap;
                    dout_d  = (!info.is_store && !trap) ? ld_data : 32'h0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // A dropped enable during WAIT lands here for exactly one cycle
                if (!RAM_enable) begin
                    state_d = ST_IDLE;
                    mae_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
            mae_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            mae_q   <= mae_d;
        end
    end

    // Storage has no reset so contents survive RESET
    assign do_write = access && info.is_store && !trap && RESET;

    always_ff @(posedge Clk) begin
        if (do_write) begin
            case (info.size)
                SZ_BYTE: Mem[eff_addr] <= din_q[7:0];
                SZ_HALF: begin
                    Mem[eff_addr]          <= din_q[15:8];
                    Mem[eff_addr + AW'(1)] <= din_q[7:0];
                end
                SZ_WORD: begin
                    Mem[word_addr]          <= din_q[31:24];
                    Mem[word_addr + AW'(1)] <= din_q[23:16];
                    Mem[word_addr + AW'(2)] <= din_q[15:8];
                    Mem[word_addr + AW'(3)] <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MFC     = (state_q == ST_DONE);
    assign MAE     = mae_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
